// File: rtl/butterfly_scheduler.sv
// Address sequencer for an in-place radix-2 DIT FFT: issues one butterfly read per cycle
// across all stages and replays each read address pair as the write-back pair D cycles later.
module butterfly_scheduler #(
    parameter int  LOG2_N     = 4,
    parameter int  RD_LATENCY = 1,
    parameter int  BF_LATENCY = 2,
    localparam int TW_W       = (LOG2_N > 1) ? LOG2_N - 1 : 1
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [LOG2_N-1:0] o_stage,
    output logic              o_rd_en,
    output logic [LOG2_N-1:0] o_rd_addr_A,
    output logic [LOG2_N-1:0] o_rd_addr_B,
    output logic [TW_W-1:0]   o_tw_addr,
    output logic              o_wr_en,
    output logic [LOG2_N-1:0] o_wr_addr_A,
    output logic [LOG2_N-1:0] o_wr_addr_B
);
    localparam int D     = RD_LATENCY + BF_LATENCY;
    localparam int CNT_W = (D > 1) ? $clog2(D) : 1;
    localparam logic [LOG2_N-1:0] ONE        = LOG2_N'(1);
    localparam logic [LOG2_N-1:0] K_LAST     = LOG2_N'((1 << (LOG2_N - 1)) - 1);
    localparam logic [LOG2_N-1:0] S_LAST     = LOG2_N'(LOG2_N - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(D - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q;
    logic [LOG2_N-1:0] s_q, k_q, s_nxt, k_nxt;
    logic [CNT_W-1:0]  drain_q;
    logic              busy_q, done_q, rd_en_q;
    logic [LOG2_N-1:0] rd_a_q, rd_b_q;
    logic [TW_W-1:0]   tw_q;
    logic              wr_en_pipe_q [D];
    logic [LOG2_N-1:0] wr_a_pipe_q  [D];
    logic [LOG2_N-1:0] wr_b_pipe_q  [D];

    function automatic logic [LOG2_N-1:0] half_of(input logic [LOG2_N-1:0] s);
        return ONE << s;
    endfunction

    // Butterfly k of stage s pairs (grp*2*half + pos) with its partner half entries above.
    function automatic logic [LOG2_N-1:0] addr_a(input logic [LOG2_N-1:0] s,
                                                 input logic [LOG2_N-1:0] k);
        logic [LOG2_N-1:0] pos, grp;
        pos = k & (half_of(s) - ONE);
        grp = k >> s;
        return (grp << (s + ONE)) | pos;
    endfunction

    function automatic logic [TW_W-1:0] tw_of(input logic [LOG2_N-1:0] s,
                                             input logic [LOG2_N-1:0] k);
        return TW_W'(k & (half_of(s) - ONE)) << (S_LAST - s);
    endfunction

    assign s_nxt = s_q + ONE;
    assign k_nxt = k_q + ONE;

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
        end else begin
            // NOTE: idle values first; a later nonblocking assignment in this pass wins.
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: if (i_start) begin
                    state_q <= RUN;
                    s_q     <= '0;
                    k_q     <= '0;
                    busy_q  <= 1'b1;
                    rd_en_q <= 1'b1;
                    rd_b_q  <= ONE;
                end
                RUN: if (k_q == K_LAST) begin
                    state_q <= DRAIN;
                    k_q     <= '0;
                    drain_q <= '0;
                end else begin
                    k_q     <= k_nxt;
                    rd_en_q <= 1'b1;
                    rd_a_q  <= addr_a(s_q, k_nxt);
                    rd_b_q  <= addr_a(s_q, k_nxt) + half_of(s_q);
                    tw_q    <= tw_of(s_q, k_nxt);
                end
                // Drain lets the last write of this stage land before the next stage reads.
                DRAIN: if (drain_q == DRAIN_LAST) begin
                    if (s_q == S_LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= RUN;
                        s_q     <= s_nxt;
                        rd_en_q <= 1'b1;
                        rd_a_q  <= '0;
                        rd_b_q  <= half_of(s_nxt);
                    end
                end else begin
                    drain_q <= drain_q + CNT_W'(1);
                end
                DONE: begin
                    state_q <= IDLE;
                    s_q     <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            // NOTE: the delay pipe is reset so an aborted run never emits a stray write strobe.
            for (int i = 0; i < D; i++) begin
                wr_en_pipe_q[i] <= 1'b0;
                wr_a_pipe_q[i]  <= '0;
                wr_b_pipe_q[i]  <= '0;
            end
        end else begin
            wr_en_pipe_q[0] <= rd_en_q;
            wr_a_pipe_q[0]  <= rd_a_q;
            wr_b_pipe_q[0]  <= rd_b_q;
            for (int i = 1; i < D; i++) begin
                wr_en_pipe_q[i] <= wr_en_pipe_q[i-1];
                wr_a_pipe_q[i]  <= wr_a_pipe_q[i-1];
                wr_b_pipe_q[i]  <= wr_b_pipe_q[i-1];
            end
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_stage     = s_q;
    assign o_rd_en     = rd_en_q;
    assign o_rd_addr_A = rd_a_q;
    assign o_rd_addr_B = rd_b_q;
    assign o_tw_addr   = tw_q;
    assign o_wr_en     = wr_en_pipe_q[D-1];
    assign o_wr_addr_A = wr_a_pipe_q[D-1];
    assign o_wr_addr_B = wr_b_pipe_q[D-1];

endmodule

// File: tb/tb_butterfly_scheduler.sv
// Bench for butterfly_scheduler (N=16, D=3): cycle-exact trace against a timing model,
// write-address scoreboard, reset abort, and a full FFT over a behavioural RAM/butterfly.
module tb_butterfly_scheduler;
    localparam int  LOG2_N = 4;
    localparam int  N      = 16;
    localparam int  HALF   = 8;
    localparam int  D      = 3;
    localparam int  P      = HALF + D;
    localparam real PI     = 3.14159265358979323846;

    logic       i_CLK = 1'b0;
    logic       i_RST = 1'b1;
    logic       i_start = 1'b0;
    logic       o_busy, o_done, o_rd_en, o_wr_en;
    logic [3:0] o_stage, o_rd_addr_A, o_rd_addr_B, o_wr_addr_A, o_wr_addr_B;
    logic [2:0] o_tw_addr;

    int n_cmp = 0;
    int n_bad = 0;

    butterfly_scheduler #(.LOG2_N(LOG2_N), .RD_LATENCY(1), .BF_LATENCY(2)) dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_stage(o_stage),
        .o_rd_en(o_rd_en), .o_rd_addr_A(o_rd_addr_A), .o_rd_addr_B(o_rd_addr_B),
        .o_tw_addr(o_tw_addr), .o_wr_en(o_wr_en),
        .o_wr_addr_A(o_wr_addr_A), .o_wr_addr_B(o_wr_addr_B)
    );

    always #5 i_CLK = ~i_CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_r(input string name, input real act, input real exp);
        n_cmp++;
        if ((act - exp > 1.0e-6) || (exp - act > 1.0e-6)) begin
            n_bad++;
            $display("FAIL %s: got %f, expected %f", name, act, exp);
        end
    endtask

    // Expected cycle-level behaviour of one run, cycle 0 = edge that samples i_start.
    typedef struct {
        int rd_en; int a; int b; int tw; int wr_en; int busy; int done; int stage;
    } exp_t;

    function automatic exp_t model(input int c);
        exp_t e;
        int   k, kw, half;
        e = '{default: 0};
        for (int s = 0; s < LOG2_N; s++) begin
            half = 1 << s;
            k    = c - 1 - P * s;
            kw   = c - 1 - D - P * s;
            if (k >= 0 && k < HALF) begin
                e.rd_en = 1;
                e.a     = (k / half) * 2 * half + (k % half);
                e.b     = e.a + half;
                e.tw    = (k % half) * (N / (2 * half));
            end
            if (kw >= 0 && kw < HALF) e.wr_en = 1;
        end
        e.busy  = (c >= 1 && c <= P * LOG2_N) ? 1 : 0;
        e.done  = (c == 1 + P * LOG2_N) ? 1 : 0;
        e.stage = e.busy ? (c - 1) / P : 0;
        return e;
    endfunction

    typedef struct { int s; int k; int a; int b; int tw; } vec_t;
    vec_t vecs [7];

    int sb_a [$];
    int sb_b [$];

    // mode 0: single pulse; 1: extra pulses on 5, 30, 45; 2: start held high.
    task automatic run_trace(input int mode);
        exp_t e;
        int   cnt;
        sb_a.delete();
        sb_b.delete();
        @(negedge i_CLK);
        i_start = 1'b1;
        @(posedge i_CLK);
        for (int c = 1; c <= 47; c++) begin
            @(negedge i_CLK);
            if (mode == 0) i_start = 1'b0;
            else if (mode == 1) i_start = (c == 5 || c == 30 || c == 45);
            e = model(c);
            if (mode == 2 && c == 47) begin
                e.rd_en = 1; e.a = 0; e.b = 1; e.busy = 1; e.stage = 0;
            end
            check($sformatf("m%0d_c%0d_rd_en", mode, c), o_rd_en, e.rd_en);
            check($sformatf("m%0d_c%0d_rd_A", mode, c), o_rd_addr_A, e.a);
            check($sformatf("m%0d_c%0d_rd_B", mode, c), o_rd_addr_B, e.b);
            check($sformatf("m%0d_c%0d_tw", mode, c), o_tw_addr, e.tw);
            check($sformatf("m%0d_c%0d_wr_en", mode, c), o_wr_en, e.wr_en);
            check($sformatf("m%0d_c%0d_busy", mode, c), o_busy, e.busy);
            check($sformatf("m%0d_c%0d_done", mode, c), o_done, e.done);
            if (e.busy) check($sformatf("m%0d_c%0d_stage", mode, c), o_stage, e.stage);
            if (mode == 0)
                foreach (vecs[i])
                    if (c == 1 + P * vecs[i].s + vecs[i].k) begin
                        check($sformatf("vec_s%0d_k%0d_A", vecs[i].s, vecs[i].k), o_rd_addr_A, vecs[i].a);
                        check($sformatf("vec_s%0d_k%0d_B", vecs[i].s, vecs[i].k), o_rd_addr_B, vecs[i].b);
                        check($sformatf("vec_s%0d_k%0d_tw", vecs[i].s, vecs[i].k), o_tw_addr, vecs[i].tw);
                    end
            if (c <= 46 && e.rd_en) begin
                sb_a.push_back(e.a);
                sb_b.push_back(e.b);
            end
            if (e.wr_en) begin
                check($sformatf("m%0d_c%0d_sb_pending", mode, c), (sb_a.size() > 0), 1);
                if (sb_a.size() > 0) begin
                    check($sformatf("m%0d_c%0d_wr_A", mode, c), o_wr_addr_A, sb_a.pop_front());
                    check($sformatf("m%0d_c%0d_wr_B", mode, c), o_wr_addr_B, sb_b.pop_front());
                end
            end
        end
        i_start = 1'b0;
        if (mode == 2) begin
            cnt = 0;
            while (o_done !== 1'b1 && cnt < 100) begin
                @(negedge i_CLK);
                cnt++;
            end
            check("held_start_second_run_done", o_done, 1);
            @(negedge i_CLK);
        end
    endtask

    // Behavioural sample RAM + twiddle ROM + butterfly, driven purely by the DUT strobes.
    real re [N];
    real im [N];
    int  wcnt [N];
    int  rd_cnt;
    bit  fft_on = 1'b0;
    real q_ar [$], q_ai [$], q_br [$], q_bi [$];
    int  fa, fb, fst;
    real ang, twr, twi, tr, ti;

    always @(negedge i_CLK) begin
        if (fft_on) begin
            if (o_rd_en === 1'b1) begin
                fa  = int'(o_rd_addr_A);
                fb  = int'(o_rd_addr_B);
                fst = rd_cnt / HALF;
                check($sformatf("fft_raw_read_%0d", rd_cnt), (wcnt[fa] == fst && wcnt[fb] == fst), 1);
                ang = -2.0 * PI * real'(int'(o_tw_addr)) / real'(N);
                twr = $cos(ang);
                twi = $sin(ang);
                tr  = re[fb] * twr - im[fb] * twi;
                ti  = re[fb] * twi + im[fb] * twr;
                q_ar.push_back(re[fa] + tr);
                q_ai.push_back(im[fa] + ti);
                q_br.push_back(re[fa] - tr);
                q_bi.push_back(im[fa] - ti);
                rd_cnt++;
            end
            if (o_wr_en === 1'b1) begin
                check("fft_pending_result", (q_ar.size() > 0), 1);
                if (q_ar.size() > 0) begin
                    re[o_wr_addr_A] = q_ar.pop_front();
                    im[o_wr_addr_A] = q_ai.pop_front();
                    re[o_wr_addr_B] = q_br.pop_front();
                    im[o_wr_addr_B] = q_bi.pop_front();
                    wcnt[o_wr_addr_A]++;
                    wcnt[o_wr_addr_B]++;
                end
            end
        end
    end

    function automatic int bitrev(input int n);
        int r;
        r = 0;
        for (int i = 0; i < LOG2_N; i++) r |= ((n >> i) & 1) << (LOG2_N - 1 - i);
        return r;
    endfunction

    task automatic run_fft(input int tone);
        int cnt;
        for (int n = 0; n < N; n++) begin
            if (tone < 0) begin
                re[bitrev(n)] = (n == 0) ? 1.0 : 0.0;
                im[bitrev(n)] = 0.0;
            end else begin
                re[bitrev(n)] = $cos(2.0 * PI * real'(tone * n) / real'(N));
                im[bitrev(n)] = $sin(2.0 * PI * real'(tone * n) / real'(N));
            end
            wcnt[n] = 0;
        end
        rd_cnt = 0;
        fft_on = 1'b1;
        @(negedge i_CLK);
        i_start = 1'b1;
        @(negedge i_CLK);
        i_start = 1'b0;
        cnt = 0;
        while (o_done !== 1'b1 && cnt < 200) begin
            @(negedge i_CLK);
            cnt++;
        end
        check("fft_done_seen", o_done, 1);
        @(negedge i_CLK);
        fft_on = 1'b0;
        check("fft_leftover_results", q_ar.size(), 0);
        for (int k = 0; k < N; k++) begin
            check($sformatf("fft_wcnt_%0d", k), wcnt[k], LOG2_N);
            if (tone < 0) begin
                check_r($sformatf("impulse_re_%0d", k), re[k], 1.0);
                check_r($sformatf("impulse_im_%0d", k), im[k], 0.0);
            end else begin
                check_r($sformatf("tone_re_%0d", k), re[k], (k == tone) ? real'(N) : 0.0);
                check_r($sformatf("tone_im_%0d", k), im[k], 0.0);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_stage"}, o_stage, 0);
        check({tag, "_rd_en"}, o_rd_en, 0);
        check({tag, "_rd_A"}, o_rd_addr_A, 0);
        check({tag, "_rd_B"}, o_rd_addr_B, 0);
        check({tag, "_tw"}, o_tw_addr, 0);
        check({tag, "_wr_en"}, o_wr_en, 0);
        check({tag, "_wr_A"}, o_wr_addr_A, 0);
        check({tag, "_wr_B"}, o_wr_addr_B, 0);
    endtask

    int n_wr, n_done, n_rd;

    initial begin
        vecs[0] = '{s: 0, k: 0, a: 0, b: 1,  tw: 0};
        vecs[1] = '{s: 0, k: 3, a: 6, b: 7,  tw: 0};
        vecs[2] = '{s: 1, k: 0, a: 0, b: 2,  tw: 0};
        vecs[3] = '{s: 1, k: 3, a: 5, b: 7,  tw: 4};
        vecs[4] = '{s: 2, k: 5, a: 9, b: 13, tw: 2};
        vecs[5] = '{s: 3, k: 5, a: 5, b: 13, tw: 5};
        vecs[6] = '{s: 3, k: 7, a: 7, b: 15, tw: 7};

        #1 i_RST = 1'b0;
        repeat (2) @(negedge i_CLK);
        check_all_zero("reset");
        i_RST = 1'b1;
        repeat (2) @(negedge i_CLK);
        check_all_zero("idle_after_reset");

        run_trace(0);
        run_trace(1);
        run_trace(2);

        // Abort in the middle of stage 2 (cycle 26: reading and writing back).
        @(negedge i_CLK);
        i_start = 1'b1;
        @(negedge i_CLK);
        i_start = 1'b0;
        repeat (25) @(negedge i_CLK);
        check("abort_pre_rd_en", o_rd_en, 1);
        check("abort_pre_wr_en", o_wr_en, 1);
        check("abort_pre_stage", o_stage, 2);
        #2 i_RST = 1'b0;
        #1 check_all_zero("abort_same_cycle");
        @(negedge i_CLK);
        i_RST = 1'b1;
        n_wr = 0; n_done = 0; n_rd = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge i_CLK);
            n_wr   += int'(o_wr_en);
            n_done += int'(o_done);
            n_rd   += int'(o_rd_en);
        end
        check("abort_no_wr_after", n_wr, 0);
        check("abort_no_done_after", n_done, 0);
        check("abort_no_rd_after", n_rd, 0);

        run_fft(-1);
        run_fft(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
